// File: rtl/serdes_pkg.sv
// serdes_pkg: frame FSM states and default sync word shared by the
// tx framer and the deserializer-side frame checker.
package serdes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_SYNC,
        W_LEN,
        REQ,
        W_DATA,
        W_CSUM
    } frame_state_e;

    localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;

endpackage

// File: rtl/serdes_tx_framer.sv
// serdes_tx_framer: wraps a payload stream into SYNC, LEN, payload, CHECKSUM
// words and feeds them one at a time to the serializer load/tx_done handshake.
module serdes_tx_framer
    import serdes_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0] SYNC_WORD = DATA_WIDTH'(SYNC_WORD_DEFAULT),
    parameter int MAX_LEN = 255
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] frame_len,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic [DATA_WIDTH-1:0] ser_data,
    output logic                  ser_load,
    input  logic                  ser_done,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  len_err
);

    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);

    frame_state_e          state, state_n;
    logic [DATA_WIDTH-1:0] rem, rem_n, csum, csum_n, data_n;
    logic                  load_n, busy_n, fdone_n, lerr_n, done_seen;

    // tx_done seen alongside our own load pulse belongs to the previous word
    assign done_seen = ser_done && !ser_load;
    assign s_ready   = (state == REQ);

    always_comb begin
        state_n = state;
        rem_n   = rem;
        csum_n  = csum;
        data_n  = ser_data;
        load_n  = 1'b0;
        busy_n  = busy;
        fdone_n = 1'b0;
        lerr_n  = 1'b0;
        case (state)
            IDLE: if (start) begin
                if (frame_len != '0 && frame_len <= MAX_LEN_W) begin
                    rem_n   = frame_len;
                    csum_n  = frame_len;
                    data_n  = SYNC_WORD;
                    load_n  = 1'b1;
                    busy_n  = 1'b1;
                    state_n = W_SYNC;
                end else begin
                    lerr_n = 1'b1;
                end
            end
            // csum still equals the latched length until the first payload word
            W_SYNC: if (done_seen) begin
                data_n  = csum;
                load_n  = 1'b1;
                state_n = W_LEN;
            end
            W_LEN: if (done_seen) state_n = REQ;
            REQ: if (s_valid) begin
                data_n  = s_data;
                csum_n  = csum ^ s_data;
                rem_n   = rem - 1'b1;
                load_n  = 1'b1;
                state_n = W_DATA;
            end
            W_DATA: if (done_seen) begin
                if (rem != '0) begin
                    state_n = REQ;
                end else begin
                    data_n  = csum;
                    load_n  = 1'b1;
                    state_n = W_CSUM;
                end
            end
            W_CSUM: if (done_seen) begin
                fdone_n = 1'b1;
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rem        <= '0;
            csum       <= '0;
            ser_data   <= '0;
            ser_load   <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            len_err    <= 1'b0;
        end else begin
            state      <= state_n;
            rem        <= rem_n;
            csum       <= csum_n;
            ser_data   <= data_n;
            ser_load   <= load_n;
            busy       <= busy_n;
            frame_done <= fdone_n;
            len_err    <= lerr_n;
        end
    end

endmodule

// File: tb/tb_serdes_tx_framer.sv
// tb_serdes_tx_framer: directed tests of the framer against a small
// behavioural serializer model with hand-computed frame words.
module tb_serdes_tx_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start = 1'b0;
    logic [7:0] frame_len = 8'h00;
    logic [7:0] s_data = 8'h00;
    logic       s_valid = 1'b0;
    logic       s_ready, ser_load, busy, frame_done, len_err, ser_done;
    logic [7:0] ser_data;

    logic       start9 = 1'b0;
    logic [8:0] len9 = 9'h000;
    logic       s_ready9, ser_load9, busy9, fd9, le9;
    logic [8:0] ser_data9;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int fd_cnt = 0;
    int le_cnt = 0;

    logic [7:0] ld_w[$];
    int         ld_c[$];
    bit         bits[$];
    logic [7:0] pay_q[$];
    int         hold = 0;
    bit         took = 1'b0;

    logic [7:0] sreg;
    int         scnt;

    serdes_tx_framer #(.DATA_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .ser_data(ser_data), .ser_load(ser_load), .ser_done(ser_done),
        .busy(busy), .frame_done(frame_done), .len_err(len_err)
    );

    serdes_tx_framer #(.DATA_WIDTH(9), .MAX_LEN(255)) dut9 (
        .clk(clk), .rst_n(rst_n), .start(start9), .frame_len(len9),
        .s_data(9'h000), .s_valid(1'b0), .s_ready(s_ready9),
        .ser_data(ser_data9), .ser_load(ser_load9), .ser_done(1'b0),
        .busy(busy9), .frame_done(fd9), .len_err(le9)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // serializer model: MSB first, tx_done rises with the last bit and holds
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt     <= 0;
            ser_done <= 1'b0;
        end else if (ser_load) begin
            sreg     <= ser_data;
            scnt     <= 8;
            ser_done <= 1'b0;
        end else if (scnt != 0) begin
            sreg <= sreg << 1;
            scnt <= scnt - 1;
            if (scnt == 2) ser_done <= 1'b1;
        end
    end

    always @(negedge clk) begin
        if (scnt != 0) bits.push_back(sreg[7]);
        if (ser_load) begin
            ld_w.push_back(ser_data);
            ld_c.push_back(cyc);
        end
        if (frame_done) fd_cnt++;
        if (len_err) le_cnt++;
    end

    initial begin
        forever begin
            @(negedge clk);
            if (took && pay_q.size() != 0) void'(pay_q.pop_front());
            if (hold > 0) begin
                s_valid = 1'b0;
                if (s_ready) hold--;
            end else begin
                s_valid = (pay_q.size() != 0);
                s_data  = (pay_q.size() != 0) ? pay_q[0] : 8'h00;
            end
            took = s_ready && s_valid;
        end
    end

    task automatic clear_log();
        ld_w.delete();
        ld_c.delete();
        bits.delete();
        fd_cnt = 0;
        le_cnt = 0;
    endtask

    task automatic pulse_start(input logic [7:0] len);
        @(negedge clk);
        frame_len = len;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_loads(input int n);
        for (int i = 0; i < 2000 && ld_w.size() < n; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (ld_w.size() < n) begin
            errors++;
            $display("FAIL wait_loads: got %0d loads, required %0d", ld_w.size(), n);
        end
    endtask

    task automatic wait_frame();
        for (int i = 0; i < 2000 && fd_cnt == 0; i++) begin
            @(negedge clk);
            #1;
        end
        checks++;
        if (fd_cnt == 0) begin
            errors++;
            $display("FAIL wait_frame: frame_done never seen");
        end
    endtask

    task automatic check_words(input string name, input logic [7:0] exp[$]);
        checks++;
        if (ld_w.size() != exp.size()) begin
            errors++;
            $display("FAIL %s count: got %0d loads, required %0d", name, ld_w.size(), exp.size());
        end
        for (int i = 0; i < exp.size(); i++) begin
            checks++;
            if (i >= ld_w.size() || ld_w[i] !== exp[i]) begin
                errors++;
                $display("FAIL %s word %0d: got %h, required %h", name, i,
                         (i < ld_w.size()) ? ld_w[i] : 8'hxx, exp[i]);
            end
        end
    endtask

    task automatic test_reset();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_load, busy, frame_done, len_err, s_ready, ser_data} !== 13'h0) begin
            errors++;
            $display("FAIL reset outputs: got %b, required 0",
                     {ser_load, busy, frame_done, len_err, s_ready, ser_data});
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [47:0] got;
        clear_log();
        pay_q = '{8'h11, 8'h22, 8'h33};
        pulse_start(8'd3);
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL basic busy: got %b, required 1", busy);
        end
        wait_frame();
        check_words("basic", '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03});
        checks++;
        if (ld_c.size() < 6 || ld_c[1] - ld_c[0] != 9) begin
            errors++;
            $display("FAIL sync_len_gap: got %0d, required 9", (ld_c.size() > 1) ? ld_c[1] - ld_c[0] : -1);
        end
        checks++;
        if (ld_c.size() < 6 || ld_c[2] - ld_c[1] != 10) begin
            errors++;
            $display("FAIL len_pay_gap: got %0d, required 10", (ld_c.size() > 2) ? ld_c[2] - ld_c[1] : -1);
        end
        checks++;
        if (ld_c.size() < 6 || ld_c[5] - ld_c[4] != 9) begin
            errors++;
            $display("FAIL pay_csum_gap: got %0d, required 9", (ld_c.size() > 5) ? ld_c[5] - ld_c[4] : -1);
        end
        got = '0;
        foreach (bits[i]) got = {got[46:0], bits[i]};
        checks++;
        if (bits.size() != 48 || got !== 48'hA503_1122_3303) begin
            errors++;
            $display("FAIL serial_stream: got %0d bits %h, required 48 bits a50311223303", bits.size(), got);
        end
        @(negedge clk);
        #1;
        checks++;
        if (fd_cnt != 1 || frame_done !== 1'b0 || busy !== 1'b0 || s_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic end: got fd_cnt=%0d frame_done=%b busy=%b s_ready=%b, required 1 0 0 0",
                     fd_cnt, frame_done, busy, s_ready);
        end
    endtask

    task automatic test_len_err();
        clear_log();
        pulse_start(8'd0);
        checks++;
        if (len_err !== 1'b1 || ser_load !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0: got len_err=%b ser_load=%b busy=%b, required 1 0 0", len_err, ser_load, busy);
        end
        @(negedge clk);
        checks++;
        if (len_err !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL len0 pulse: got len_err=%b busy=%b, required 0 0", len_err, busy);
        end
        @(negedge clk);
        len9 = 9'd256;
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        checks++;
        if (le9 !== 1'b1 || ser_load9 !== 1'b0 || busy9 !== 1'b0) begin
            errors++;
            $display("FAIL len256: got len_err=%b ser_load=%b busy=%b, required 1 0 0", le9, ser_load9, busy9);
        end
        len9 = 9'd255;
        start9 = 1'b1;
        @(negedge clk);
        start9 = 1'b0;
        checks++;
        if (le9 !== 1'b0 || ser_load9 !== 1'b1 || busy9 !== 1'b1 || ser_data9 !== 9'h0A5) begin
            errors++;
            $display("FAIL len255: got len_err=%b ser_load=%b busy=%b data=%h, required 0 1 1 0a5",
                     le9, ser_load9, busy9, ser_data9);
        end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_hold();
        int bad = 0;
        clear_log();
        hold = 20;
        pay_q = '{8'hC3, 8'h3C};
        pulse_start(8'd2);
        for (int i = 0; i < 500 && !s_ready; i++) begin
            @(negedge clk);
            #1;
        end
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (s_ready !== 1'b1 || ser_load !== 1'b0) begin
                errors++;
                $display("FAIL hold cycle %0d: got s_ready=%b ser_load=%b, required 1 0", i, s_ready, ser_load);
            end
            @(negedge clk);
            #1;
        end
        wait_frame();
        check_words("hold", '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD});
    endtask

    task automatic test_start_in_len();
        clear_log();
        pay_q = '{8'h01, 8'h02};
        pulse_start(8'd2);
        wait_loads(2);
        pulse_start(8'd7);
        wait_frame();
        check_words("start_in_len", '{8'hA5, 8'h02, 8'h01, 8'h02, 8'h01});
        checks++;
        if (le_cnt != 0) begin
            errors++;
            $display("FAIL start_in_len len_err: got %0d pulses, required 0", le_cnt);
        end
    endtask

    task automatic test_reset_mid();
        clear_log();
        pay_q = '{8'hAA, 8'hBB, 8'hCC};
        pulse_start(8'd3);
        wait_loads(4);
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || ser_data !== 8'hBB) begin
            errors++;
            $display("FAIL mid frame: got busy=%b data=%h, required 1 bb", busy, ser_data);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({ser_load, busy, frame_done, len_err, s_ready, ser_data} !== 13'h0) begin
            errors++;
            $display("FAIL async reset: got %b, required 0",
                     {ser_load, busy, frame_done, len_err, s_ready, ser_data});
        end
        pay_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        clear_log();
        pay_q = '{8'h5A};
        pulse_start(8'd1);
        wait_frame();
        check_words("after_reset", '{8'hA5, 8'h01, 8'h5A, 8'h5B});
    endtask

    initial begin
        test_reset();
        test_basic();
        test_len_err();
        test_hold();
        test_start_in_len();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
